// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding and memory geometry.
package im_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CHK  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam int IM_BYTES   = 2048;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/im_loader_word_pack.sv
// Groups accepted stream bytes into 32-bit words and flags the fourth byte of each word.
// The assembled big-endian word is only built when IM_LOADER_CHECKSUM_EN is defined.
module im_word_pack
  import im_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_valid,
`ifdef IM_LOADER_CHECKSUM_EN
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
`endif
  output logic        o_word_done
);

  logic [1:0] idx_q, idx_d;

  assign o_word_done = i_valid && (idx_q == 2'(WORD_BYTES - 1));

  // byte position inside the current word
  always_comb begin
    if (i_clr) begin
      idx_d = 2'd0;
    end else if (i_valid) begin
      idx_d = idx_q + 2'd1;
    end else begin
      idx_d = idx_q;
    end
  end

  // byte position register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx_q <= 2'd0;
    end else begin
      idx_q <= idx_d;
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  logic [23:0] sh_q, sh_d;

  // the current byte completes the word combinationally so the caller sees it on the fourth byte
  assign o_word = {sh_q, i_byte};

  // shift earlier bytes toward the MSB end
  always_comb begin
    if (i_valid) begin
      sh_d = {sh_q[15:0], i_byte};
    end else begin
      sh_d = sh_q;
    end
  end

  // shift register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sh_q <= 24'h000000;
    end else begin
      sh_q <= sh_d;
    end
  end
`endif

endmodule

// File: rtl/im_loader.sv
// Byte-stream loader that writes a program image into instruction memory while stalling the CPU.
// Define IM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word after the data.
module im_loader
  import im_pkg::*;
#(
  parameter int MEM_BYTES = IM_BYTES,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  i_num_words,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  words_left_q, words_left_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept_s;
  logic              start_s;
  logic              pack_done_s;
  logic [ADDR_W-1:0] base_al_s;
  logic [ADDR_W:0]   end_s;
  logic              range_bad_s;

`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0]       xor_q, xor_d;
  logic [31:0]       pack_word_s;
  logic              chk_ok_q, chk_ok_d;

  assign o_byte_ready = (state_q == S_LOAD) || (state_q == S_CHK);
`else
  assign o_byte_ready = (state_q == S_LOAD);
`endif

  assign o_busy      = (state_q != S_IDLE);
  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_cpu_hold  = hold_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

  assign accept_s    = i_byte_valid && o_byte_ready;
  assign start_s     = i_start && (state_q == S_IDLE);
  assign base_al_s   = i_base_addr & ~ADDR_W'(2'd3);
  // one extra bit so a base near the top of the address space cannot wrap past the check
  assign end_s       = (ADDR_W+1)'(base_al_s) + (ADDR_W+1)'(i_num_words) * (ADDR_W+1)'(WORD_BYTES);
  assign range_bad_s = end_s > (ADDR_W+1)'(MEM_BYTES);

  im_word_pack u_pack (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (start_s),
    .i_valid     (accept_s),
`ifdef IM_LOADER_CHECKSUM_EN
    .i_byte      (i_byte_data),
    .o_word      (pack_word_s),
`endif
    .o_word_done (pack_done_s)
  );

  // load sequencing, hold and completion status
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    hold_d       = hold_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
    xor_d        = xor_q;
    chk_ok_d     = chk_ok_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (range_bad_s) begin
            err_d = 1'b1;
          end else begin
            hold_d       = 1'b1;
            addr_d       = base_al_s;
            words_left_d = i_num_words;
`ifdef IM_LOADER_CHECKSUM_EN
            xor_d        = 32'h0000_0000;
            chk_ok_d     = 1'b1;
`endif
            if (i_num_words == {CNT_W{1'b0}}) begin
              state_d = S_FIN;
            end else begin
              state_d = S_LOAD;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (accept_s) begin
          addr_d = addr_q + ADDR_W'(1'b1);
          if (pack_done_s) begin
            words_left_d = words_left_q - CNT_W'(1'b1);
`ifdef IM_LOADER_CHECKSUM_EN
            xor_d        = xor_q ^ pack_word_s;
`endif
            if (words_left_q == CNT_W'(1'b1)) begin
`ifdef IM_LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_FIN;
`endif
            end else begin
              state_d = S_LOAD;
            end
          end else begin
            words_left_d = words_left_q;
          end
        end else begin
          addr_d = addr_q;
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept_s && pack_done_s) begin
          chk_ok_d = (pack_word_s == xor_q);
          state_d  = S_FIN;
        end else begin
          state_d  = S_CHK;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        hold_d  = 1'b0;
        done_d  = chk_ok_q;
        err_d   = !chk_ok_q;
      end
`else
      S_FIN: begin
        state_d = S_IDLE;
        hold_d  = 1'b0;
        done_d  = 1'b1;
      end
      S_CHK: begin
        state_d = S_IDLE;
        hold_d  = 1'b0;
      end
`endif
      default: begin
        state_d = S_IDLE;
        hold_d  = 1'b0;
      end
    endcase
  end

  // memory write port: one cycle behind byte acceptance, checksum bytes are never written
  always_comb begin
    if (accept_s && (state_q == S_LOAD)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = i_byte_data;
    end else begin
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
  end

  // state and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      addr_q       <= {ADDR_W{1'b0}};
      words_left_q <= {CNT_W{1'b0}};
      wr_en_q      <= 1'b0;
      wr_addr_q    <= {ADDR_W{1'b0}};
      wr_data_q    <= 8'h00;
      hold_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      xor_q        <= 32'h0000_0000;
      chk_ok_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef IM_LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
      chk_ok_q     <= chk_ok_d;
`endif
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: cycle-level reference model plus directed image loads and random loads.
// Builds with or without IM_LOADER_CHECKSUM_EN; the checksum trailer is appended to streams when enabled.
module tb_im_loader;

  localparam int ADDR_W    = 32;
  localparam int CNT_W     = 10;
  localparam int MEM_BYTES = 2048;
`ifdef IM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  num;
  logic              valid;
  logic [7:0]        bdata;
  logic              o_byte_ready, o_wr_en, o_cpu_hold, o_busy, o_done, o_err;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [7:0]        o_wr_data;

  always #5 clk = ~clk;

  im_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_base_addr(base), .i_num_words(num),
    .i_byte_valid(valid), .i_byte_data(bdata), .o_byte_ready(o_byte_ready), .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_cpu_hold(o_cpu_hold), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  int n_cmp = 0, n_fail = 0, n_wr = 0, n_done = 0, n_err = 0;
  logic [7:0]  imem [0:MEM_BYTES-1];
  logic [7:0]  stream [$];
  logic [31:0] words [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {imem[a], imem[a+1], imem[a+2], imem[a+3]};
  endfunction

  // Reference model: what each output must be in the cycle following this edge.
  logic        e_ready = 1'b0, e_busy = 1'b0, e_hold = 1'b0, e_wr = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [31:0] e_addr = 32'h0;
  logic [7:0]  e_data = 8'h0;
  bit          m_active = 1'b0, m_fin = 1'b0;
  int          m_total = 0, m_data = 0, m_got = 0;
  logic [31:0] m_base = 32'h0, m_xor = 32'h0, m_chk = 32'h0;

  always @(posedge clk) begin : model
    logic   acc;
    longint endaddr;
    acc    = e_ready && valid;
    e_wr   = 1'b0;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_fin    = 1'b0;
      e_hold   = 1'b0;
    end else if (m_fin) begin
      e_done   = !CK || (m_chk == m_xor);
      e_err    = !e_done;
      e_hold   = 1'b0;
      m_active = 1'b0;
      m_fin    = 1'b0;
    end else if (!m_active) begin
      if (i_start) begin
        m_base  = base & ~32'd3;
        endaddr = longint'(m_base) + 4 * longint'(num);
        if (endaddr > MEM_BYTES) begin
          e_err = 1'b1;
        end else begin
          m_active = 1'b1;
          e_hold   = 1'b1;
          m_data   = 4 * int'(num);
          m_total  = (num == 0) ? 0 : m_data + (CK ? 4 : 0);
          m_got    = 0;
          m_xor    = 32'h0;
          m_chk    = 32'h0;
          m_fin    = (num == 0);
        end
      end
    end else if (acc) begin
      if (m_got < m_data) begin
        e_wr   = 1'b1;
        e_addr = m_base + 32'(m_got);
        e_data = bdata;
        m_xor  = m_xor ^ (32'(bdata) << (8 * (3 - (m_got % 4))));
      end else begin
        m_chk = {m_chk[23:0], bdata};
      end
      m_got++;
      if (m_got == m_total) m_fin = 1'b1;
    end
    e_ready = m_active && !m_fin && (m_got < m_total);
    e_busy  = m_active;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("ready", o_byte_ready, e_ready);
    check("busy", o_busy, e_busy);
    check("hold", o_cpu_hold, e_hold);
    check("wr_en", o_wr_en, e_wr);
    check("done", o_done, e_done);
    check("err", o_err, e_err);
    if (e_wr) begin
      check("wr_addr", o_wr_addr, e_addr);
      check("wr_data", o_wr_data, e_data);
    end
  end

  // Instruction memory image and event counters taken from the write port.
  always @(negedge clk) begin
    if (o_wr_en === 1'b1) begin
      n_wr++;
      imem[o_wr_addr[10:0]] = o_wr_data;
    end
    if (o_done === 1'b1) n_done++;
    if (o_err === 1'b1) n_err++;
  end

  task automatic build(input bit bad);
    logic [31:0] x;
    x = 32'h0;
    stream.delete();
    foreach (words[i]) begin
      x = x ^ words[i];
      for (int k = 3; k >= 0; k--) stream.push_back(8'(words[i] >> (8 * k)));
    end
    if (CK && words.size() > 0) begin
      if (bad) x = x ^ 32'h1;
      for (int k = 3; k >= 0; k--) stream.push_back(8'(x >> (8 * k)));
    end
  endtask

  task automatic do_load(input logic [31:0] b, input int n, input int mode, input int abort_at, input bit stray);
    int idx, budget, t;
    bit v, rdy;
    @(negedge clk);
    i_start = 1'b1;
    base    = b;
    num     = CNT_W'(n);
    valid   = 1'($urandom);
    bdata   = 8'($urandom);
    @(negedge clk);
    i_start = 1'b0;
    valid   = 1'b0;
    idx = 0; budget = 400; t = 0;
    while (idx < stream.size() && budget > 0) begin
      if (abort_at > 0 && idx == abort_at) break;
      rdy = o_byte_ready;
      case (mode)
        0:       v = 1'b1;
        1:       v = (t % 4 == 0) || (t % 4 == 3);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      valid = v;
      bdata = v ? stream[idx] : 8'($urandom);
      if (stray && $urandom_range(0, 7) == 0) begin
        i_start = 1'b1;
        base    = $urandom;
        num     = CNT_W'($urandom);
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      if (v && rdy) idx++;
      t++;
      budget--;
    end
    i_start = 1'b0;
    valid   = 1'b0;
    if (budget == 0) check("stream_timeout", idx, stream.size());
    if (abort_at == 0) begin
      budget = 40;
      while (o_busy === 1'b1 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (budget == 0) check("busy_timeout", o_busy, 32'h0);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic clear_imem();
    for (int a = 0; a < MEM_BYTES; a++) imem[a] = 8'h00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w0, d0, e0;
    int n;
    logic [31:0] b;
    rst = 1'b1; i_start = 1'b0; base = 32'h0; num = '0; valid = 1'b0; bdata = 8'h00;
    clear_imem();
    #1;
    check("rst_ready", o_byte_ready, 32'h0);
    check("rst_busy", o_busy, 32'h0);
    check("rst_hold", o_cpu_hold, 32'h0);
    check("rst_wr_en", o_wr_en, 32'h0);
    check("rst_done", o_done, 32'h0);
    check("rst_err", o_err, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // basic load, valid every cycle
    words.delete(); words.push_back(32'h20080005); words.push_back(32'h8C090004); build(1'b0);
    w0 = n_wr; d0 = n_done;
    do_load(32'h0, 2, 0, 0, 1'b0);
    check("basic_writes", n_wr - w0, 32'd8);
    check("basic_done", n_done - d0, 32'd1);
    check("basic_word0", word_at(0), 32'h20080005);
    check("basic_word4", word_at(4), 32'h8C090004);

    // same image with 1,0,0,1 valid gaps
    clear_imem();
    w0 = n_wr; d0 = n_done;
    do_load(32'h0, 2, 1, 0, 1'b0);
    check("gap_writes", n_wr - w0, 32'd8);
    check("gap_done", n_done - d0, 32'd1);
    check("gap_word0", word_at(0), 32'h20080005);
    check("gap_word4", word_at(4), 32'h8C090004);

    // range error
    stream.delete();
    w0 = n_wr; d0 = n_done; e0 = n_err;
    do_load(32'h7FC, 2, 0, 0, 1'b0);
    check("range_err", n_err - e0, 32'd1);
    check("range_writes", n_wr - w0, 32'd0);
    check("range_done", n_done - d0, 32'd0);

    // zero words
    stream.delete();
    w0 = n_wr; d0 = n_done;
    do_load(32'h100, 0, 0, 0, 1'b0);
    check("zero_done", n_done - d0, 32'd1);
    check("zero_writes", n_wr - w0, 32'd0);

    // misaligned base lands on the word boundary below it
    words.delete(); words.push_back(32'hA1B2C3D4); build(1'b0);
    w0 = n_wr;
    do_load(32'h13, 1, 2, 0, 1'b0);
    check("misal_writes", n_wr - w0, 32'd4);
    check("misal_word", word_at(32'h10), 32'hA1B2C3D4);

    // reset after the third accepted byte, then a clean reload
    words.delete(); words.push_back(32'h11223344); words.push_back(32'h55667788); build(1'b0);
    d0 = n_done;
    do_load(32'h40, 2, 0, 3, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("abort_ready", o_byte_ready, 32'h0);
    check("abort_busy", o_busy, 32'h0);
    check("abort_hold", o_cpu_hold, 32'h0);
    check("abort_wr_en", o_wr_en, 32'h0);
    check("abort_wr_addr", o_wr_addr, 32'h0);
    check("abort_done", o_done, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_no_done", n_done - d0, 32'd0);
    do_load(32'h40, 2, 2, 0, 1'b0);
    check("reload_word0", word_at(32'h40), 32'h11223344);
    check("reload_word4", word_at(32'h44), 32'h55667788);

`ifdef IM_LOADER_CHECKSUM_EN
    // checksum trailer: good word completes, corrupted word reports an error
    words.delete(); words.push_back(32'h20080005); words.push_back(32'h8C090004); build(1'b0);
    check("ck_stream_tail", {stream[8], stream[9], stream[10], stream[11]}, 32'hAC010001);
    d0 = n_done; e0 = n_err;
    do_load(32'h200, 2, 0, 0, 1'b0);
    check("ck_good_done", n_done - d0, 32'd1);
    check("ck_good_err", n_err - e0, 32'd0);
    build(1'b1);
    d0 = n_done; e0 = n_err;
    do_load(32'h200, 2, 1, 0, 1'b0);
    check("ck_bad_done", n_done - d0, 32'd0);
    check("ck_bad_err", n_err - e0, 32'd1);
`endif

    // random loads with gaps, stray starts and occasional out-of-range bases
    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(0, 10);
      case ($urandom_range(0, 9))
        0:       b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        1, 2:    b = 32'($urandom_range(MEM_BYTES - 40, MEM_BYTES + 40));
        default: b = 32'($urandom_range(0, MEM_BYTES - 4 * n - 1));
      endcase
      words.delete();
      if (longint'(b & ~32'd3) + 4 * n <= MEM_BYTES) begin
        for (int k = 0; k < n; k++) words.push_back($urandom);
      end
      build($urandom_range(0, 3) == 0);
      do_load(b, n, $urandom_range(0, 2), 0, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Write-side counterpart to the byte-addressed, big-endian instruction memory. Accepts a byte stream from a host/testbench link over a valid/ready handshake and writes the bytes into instruction-memory byte storage. Each 32-bit word is stored MSB first, at addresses base+0 .. base+3.
- Sits between the program-download path and the instruction memory's write port. Holds the CPU stalled until the image is complete.

Parameters:
- MEM_BYTES, 2048, instruction memory depth in bytes.
- ADDR_W, 32, width of the byte address, matching the CPU instruction address.
- CNT_W, 10, width of the word-count input (max 1023 words).

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  one-cycle pulse that begins a load.
- i_base_addr  input  ADDR_W  byte address of the first word; sampled on i_start; bits [1:0] forced to 0.
- i_num_words  input  CNT_W  number of 32-bit words to load; sampled on i_start.
- i_byte_valid  input  1  i_byte_data is valid.
- i_byte_data  input  8  stream byte.
- o_byte_ready  output  1  loader accepts a byte this cycle.
- o_wr_en  output  1  byte write strobe to the memory.
- o_wr_addr  output  ADDR_W  byte write address.
- o_wr_data  output  8  byte write data.
- o_cpu_hold  output  1  keeps the CPU PC/fetch stalled.
- o_busy  output  1  a load is in progress.
- o_done  output  1  one-cycle pulse when a load completes successfully.
- o_err  output  1  one-cycle pulse on a range or checksum error.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0. Reset mid-load aborts immediately. Bytes already written stay in memory; no rollback.
- FSM states: IDLE, LOAD, CHK (only with the optional feature), FIN.
- IDLE:
  - o_byte_ready=0.
  - On i_start, the range check is base + 4*num_words > MEM_BYTES.
  - If the range check fails: o_err pulses next cycle, FSM stays IDLE, no writes.
  - If num_words==0: go to FIN.
  - Otherwise: latch the address and word count, go to LOAD.
- LOAD:
  - o_byte_ready=1, o_busy=1.
  - A byte is accepted when i_byte_valid && o_byte_ready.
  - Latency 1: the cycle after acceptance, o_wr_en=1, with o_wr_addr = current address and o_wr_data = the accepted byte.
  - The address increments by 1 per accepted byte.
  - After byte 4*num_words-1 is accepted, go to FIN (or CHK when the optional feature is enabled).
  - i_byte_valid low simply stalls; there is no timeout.
- FIN: o_done=1 for exactly one cycle, then IDLE.
- o_cpu_hold:
  - Asserts the cycle after an accepted i_start (including num_words==0).
  - Deasserts in the same cycle o_done is high.
  - Stays 1 through the final o_wr_en.
- i_start while o_busy=1 is ignored.
- The final byte's write strobe coincides with the FIN cycle.
- No bytes are accepted outside LOAD/CHK. Stream bytes presented in IDLE are not consumed.
- Address arithmetic is ADDR_W bits unsigned. The range check prevents wrap-around.

Optional Feature:
- Macro: IM_LOADER_CHECKSUM_EN.
- Enabled:
  - Each group of 4 loaded bytes is assembled big-endian into a word; a running 32-bit XOR of all words starts at 0.
  - After the data, state CHK accepts 4 more bytes (big-endian checksum word). These bytes are not written to memory.
  - Match: o_done pulses. Mismatch: o_err pulses instead of o_done.
  - o_cpu_hold drops in either case.
- Disabled: no CHK state and no accumulator; the load ends after the data bytes.

Decomposition:
- Shared package im_pkg holds:
  - the state encoding (IDLE=0, LOAD=1, CHK=2, FIN=3);
  - IM_BYTES=2048 and the word-size constant 4.
- One natural sub-module: im_word_pack. It assembles 4 bytes into a big-endian word and flags word completion; it is used by the checksum accumulator.

Test Plan:
- Basic load: base=0x0, num_words=2, bytes 0x20,0x08,0x00,0x05,0x8C,0x09,0x00,0x04, valid every cycle -> 8 writes to addresses 0..7 with matching data, each 1 cycle after acceptance. Read back through the instruction memory: 0x20080005 at 0, 0x8C090004 at 4. o_done pulses once; o_cpu_hold high from start+1 until done.
- Backpressure/gaps: same image with i_byte_valid toggling 1,0,0,1 -> identical memory contents; no writes in idle-valid cycles.
- Range error: base=0x7FC, num_words=2 -> o_err pulse, no o_wr_en, o_cpu_hold stays 0.
- Zero words and misaligned base: num_words=0 -> o_done 2 cycles after i_start, no writes. base=0x13, num_words=1 -> writes at 0x10..0x13.
- Reset mid-load: assert i_rst after the 3rd accepted byte of a 2-word load -> all outputs 0 immediately. A following clean load works normally.
- Checksum (IM_LOADER_CHECKSUM_EN): words 0x20080005, 0x8C090004 plus checksum 0xAC010001 -> o_done. Checksum 0xAC010000 -> o_err, no o_done.
